uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter
// among NREQ byte producers, with a watchdog on frame start.
//
// Handshake semantics: a requester holds req_valid high with stable data
// until it sees req_ready; req_ready is a one-cycle one-hot pulse, raised
// only in IDLE, and the transfer completes in that same cycle. On the
// transmitter side tx_valid stays high while in ISSUE until tx_busy or
// tx_done is seen; tx_data is held from accept until the next accept.
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int DATA_W        = 8,
  parameter int ISSUE_TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_valid,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     active,
  output logic                     err_timeout,
  output logic [1:0]               dbg_state
);

  localparam int GID_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(ISSUE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ISSUE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [GID_W-1:0]   r_ptr;
  logic [GID_W-1:0]   r_grant_id;
  logic [DATA_W-1:0]  r_tx_data;
  logic [CNT_W-1:0]   r_count;
  logic               r_err_timeout;

  logic               w_found;
  logic [GID_W-1:0]   w_gnt;
  logic               w_complete;
  logic               w_timeout;
  logic [GID_W-1:0]   w_ptr_next;

  // Modulo-NREQ wrap so non-power-of-two requester counts rotate correctly.
  function automatic logic [GID_W-1:0] wrap_idx(input int v);
    return GID_W'(v % NREQ);
  endfunction

  // Round-robin search: first valid requester starting at r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[wrap_idx(int'(r_ptr) + k)]) begin
        w_found = 1'b1;
        w_gnt   = wrap_idx(int'(r_ptr) + k);
      end
    end
  end

  // Pointer moves just past the requester whose frame just ended.
  always_comb begin
    w_ptr_next = (r_grant_id == GID_W'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
  end

  // Next-state logic; tx_done takes priority over tx_busy in ISSUE.
  always_comb begin
    w_next     = r_state;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (tx_done) begin
          w_next     = S_IDLE;
          w_complete = 1'b1;
        end else if (tx_busy) begin
          w_next = S_WAIT_DONE;
        end else if (r_count == CNT_LAST) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        // A busy drop without done is ignored; only done ends the frame.
        if (tx_done) begin
          w_next     = S_IDLE;
          w_complete = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, grant, data, watchdog counter and error pulse registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_grant_id    <= '0;
      r_tx_data     <= '0;
      r_count       <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_err_timeout <= w_timeout;
      if (w_complete || w_timeout) r_ptr <= w_ptr_next;
      if (r_state == S_IDLE && w_found) begin
        r_tx_data  <= req_data[w_gnt*DATA_W +: DATA_W];
        r_grant_id <= w_gnt;
        r_count    <= '0;
      end else if (r_state == S_ISSUE && w_next == S_ISSUE) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Output decode; req_ready only in IDLE and one-hot by construction.
  always_comb begin
    req_ready   = (r_state == S_IDLE && w_found) ? (NREQ'(1) << w_gnt) : '0;
    tx_valid    = (r_state == S_ISSUE);
    tx_data     = r_tx_data;
    grant_id    = r_grant_id;
    active      = (r_state != S_IDLE);
    err_timeout = r_err_timeout;
    dbg_state   = r_state;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, DATA_W=8, ISSUE_TIMEOUT=8).
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               tx_valid;
  logic [DW-1:0]      tx_data;
  logic               tx_busy;
  logic               tx_done;
  logic [1:0]         grant_id;
  logic               active;
  logic               err_timeout;
  logic [1:0]         dbg_state;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ISSUE_TIMEOUT(8)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // Driver tasks: inputs change 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check 2 ns after inputs settle, far from either clock edge.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    nrst = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
    cyc(); cyc();
    #2;
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_active", 32'(active), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_ready", 32'(req_ready), 0);
    nrst = 1'b1;
    cyc();

    // 1: single requester 2, data A5
    req_data = 32'hC3A50000; req_valid = 4'b0100;
    #2 check("t1_ready", 32'(req_ready), 32'h4);
    check("t1_idle", 32'(active), 0);
    cyc(); req_valid = '0;
    #2 check("t1_ready_off", 32'(req_ready), 0);
    check("t1_tx_valid", 32'(tx_valid), 1);
    check("t1_tx_data", 32'(tx_data), 32'hA5);
    check("t1_grant", 32'(grant_id), 2);
    tx_busy = 1'b1; cyc(); tx_busy = 1'b0;
    #2 check("t1_valid_drop", 32'(tx_valid), 0);
    check("t1_active_wait", 32'(active), 1);
    cyc();
    #2 check("t1_busy_drop_ignored", 32'(active), 1);
    tx_done = 1'b1; cyc(); tx_done = 1'b0;
    #2 check("t1_back_idle", 32'(active), 0);
    check("t1_grant_hold", 32'(grant_id), 2);
    check("t1_data_hold", 32'(tx_data), 32'hA5);
    // ptr should now be 3
    req_valid = 4'b1111;
    #2 check("t1_ptr3", 32'(req_ready), 32'h8);
    cyc(); req_valid = '0;
    #2 check("t1_grant3", 32'(grant_id), 3);
    check("t1_data3", 32'(tx_data), 32'hC3);
    // done without busy in ISSUE counts as complete
    tx_done = 1'b1; cyc(); tx_done = 1'b0;
    #2 check("t1_done_no_busy", 32'(active), 0);

    // 2 + 5: requesters 0 and 3 from reset
    nrst = 1'b0; cyc(); nrst = 1'b1;
    req_data = 32'h33000011; req_valid = 4'b1001;
    #2 check("t2_ready0", 32'(req_ready), 32'h1);
    cyc(); req_valid = 4'b1000;
    #2 check("t2_no_ready_busy", 32'(req_ready), 0);
    check("t2_data0", 32'(tx_data), 32'h11);
    check("t2_grant0", 32'(grant_id), 0);
    tx_busy = 1'b1; cyc(); tx_busy = 1'b0;
    #2 check("t2_no_ready_wait", 32'(req_ready), 0);
    tx_done = 1'b1; cyc(); tx_done = 1'b0;
    #2 check("t2_ready3_after_done", 32'(req_ready), 32'h8);
    check("t2_bubble_tx_valid", 32'(tx_valid), 0);
    cyc(); req_valid = '0;
    #2 check("t2_tx_valid3", 32'(tx_valid), 1);
    check("t2_data3", 32'(tx_data), 32'h33);
    check("t2_grant3", 32'(grant_id), 3);
    tx_done = 1'b1; cyc(); tx_done = 1'b0;

    // 3: all four continuously valid for 8 frames; ptr is 0 here
    req_data = 32'h44332211; req_valid = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      #2 check("t3_ready", 32'(req_ready), 32'(1) << (f % 4));
      check("t3_bubble", 32'(tx_valid), 0);
      cyc();
      #2 check("t3_grant", 32'(grant_id), 32'(f % 4));
      check("t3_data", 32'(tx_data), 32'((f % 4) + 1) * 32'h11);
      check("t3_tx_valid", 32'(tx_valid), 1);
      tx_busy = 1'b1; cyc(); tx_busy = 1'b0;
      tx_done = 1'b1; cyc(); tx_done = 1'b0;
      if (f == 7) req_valid = '0;
    end

    // 4: watchdog with busy held low; ptr is 0, requester 1 alone
    req_valid = 4'b0010;
    #2 check("t4_ready1", 32'(req_ready), 32'h2);
    cyc(); req_valid = '0;
    for (int i = 0; i < 8; i++) begin
      #2 check("t4_tx_valid_hi", 32'(tx_valid), 1);
      check("t4_no_err_yet", 32'(err_timeout), 0);
      cyc();
    end
    #2 check("t4_tx_valid_lo", 32'(tx_valid), 0);
    check("t4_err_pulse", 32'(err_timeout), 1);
    check("t4_idle", 32'(active), 0);
    cyc();
    #2 check("t4_err_one_cycle", 32'(err_timeout), 0);
    req_valid = 4'b1111;
    #2 check("t4_next_grant2", 32'(req_ready), 32'h4);
    cyc(); req_valid = '0;
    // simultaneous busy and done: done wins
    tx_busy = 1'b1; tx_done = 1'b1; cyc(); tx_busy = 1'b0; tx_done = 1'b0;
    #2 check("t4_done_wins", 32'(active), 0);

    // 6: reset during WAIT_DONE; ptr is 3 before the reset
    req_data = 32'h77000066; req_valid = 4'b0001;
    #2 check("t6_ready0", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    tx_busy = 1'b1; cyc();
    #2 check("t6_in_wait", 32'(dbg_state), 2);
    nrst = 1'b0; cyc(); tx_busy = 1'b0; nrst = 1'b1;
    #2 check("t6_rst_active", 32'(active), 0);
    check("t6_rst_data", 32'(tx_data), 0);
    check("t6_rst_grant", 32'(grant_id), 0);
    check("t6_rst_err", 32'(err_timeout), 0);
    check("t6_rst_ready", 32'(req_ready), 0);
    cyc();
    #2 check("t6_err_stays0", 32'(err_timeout), 0);
    req_valid = 4'b1001;
    #2 check("t6_ptr0", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    #2 check("t6_data", 32'(tx_data), 32'h66);
    check("t6_tx_valid", 32'(tx_valid), 1);
    tx_done = 1'b1; cyc(); tx_done = 1'b0;
    #2 check("t6_done", 32'(active), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
